data_sram_resp: RTL and testbench



---
 rtl/data_sram_resp_pkg.sv | 28 ++
 rtl/data_sram_resp_ram.sv | 29 ++
 rtl/data_sram_resp.sv | 105 ++++++++++
 tb/tb_data_sram_resp.sv | 188 ++++++++++++++++++
 4 files changed

// File: rtl/data_sram_resp_pkg.sv
// Shared constants and helpers for the data-SRAM responder: MMIO map and
// the byte-lane merge used by every byte-enabled register.
package data_sram_resp_pkg;

    localparam logic [31:0] MMIO_BASE_DEFAULT = 32'hBFAF_0000;

    localparam logic [15:0] OFF_LED    = 16'h0000;
    localparam logic [15:0] OFF_TIMER  = 16'h0004;
    localparam logic [15:0] OFF_SWITCH = 16'h0008;

    // Which source drives rdata for the request captured last cycle.
    typedef enum logic {
        TAG_MMIO = 1'b0,
        TAG_RAM  = 1'b1
    } rsel_e;

    function automatic logic [31:0] byte_merge(input logic [31:0] old_v,
                                               input logic [31:0] wdata,
                                               input logic [3:0]  we);
        logic [31:0] r;
        r = old_v;
        for (int i = 0; i < 4; i++) begin
            if (we[i]) r[8*i +: 8] = wdata[8*i +: 8];
        end
        return r;
    endfunction

endpackage

// File: rtl/data_sram_resp_ram.sv
// Single-port, read-first, byte-write-enabled synchronous RAM. Contents are
// deliberately not reset so it maps onto block RAM.
module data_ram_core #(
    parameter int ADDR_WIDTH = 12
) (
    input  logic                  clk,
    input  logic                  en_i,
    input  logic [3:0]            we_i,
    input  logic [ADDR_WIDTH-1:0] addr_i,
    input  logic [31:0]           wdata_i,
    output logic [31:0]           rdata_o
);

    logic [31:0] mem_q [0:(1<<ADDR_WIDTH)-1];
    logic [31:0] rdata_q;

    // Read samples the old word in the same cycle a store updates it.
    always_ff @(posedge clk) begin
        if (en_i) begin
            rdata_q <= mem_q[addr_i];
            for (int i = 0; i < 4; i++) begin
                if (we_i[i]) mem_q[addr_i][8*i +: 8] <= wdata_i[8*i +: 8];
            end
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/data_sram_resp.sv
// Data-SRAM responder: region decode, RAM, MMIO registers (LED, timer,
// synchronized switches) and a registered one-cycle-latency read port.
module data_sram_resp
    import data_sram_resp_pkg::*;
#(
    parameter int          ADDR_WIDTH = 12,
    parameter logic [31:0] MMIO_BASE  = MMIO_BASE_DEFAULT,
    parameter int          LED_WIDTH  = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 data_sram_en,
    input  logic [3:0]           data_sram_we,
    input  logic [31:0]          data_sram_addr,
    input  logic [31:0]          data_sram_wdata,
    output logic [31:0]          data_sram_rdata,
    input  logic [15:0]          switch_in,
    output logic [LED_WIDTH-1:0] led_out
);

    logic                 is_mmio, is_store, ram_en;
    logic [15:0]          offset;
    logic [31:0]          ram_rdata, mmio_rd, led_merged;
    logic                 unused_addr;

    logic [LED_WIDTH-1:0] led_q, led_d;
    logic [31:0]          timer_q, timer_d;
    logic [31:0]          mmio_rdata_q, mmio_rdata_d;
    rsel_e                tag_q, tag_d;
    logic [15:0]          sw_meta_q, sw_sync_q;

    assign is_mmio     = (data_sram_addr[31:16] == MMIO_BASE[31:16]);
    assign offset      = data_sram_addr[15:0];
    assign is_store    = |data_sram_we;
    assign ram_en      = data_sram_en && !reset && !is_mmio;
    assign unused_addr = ^data_sram_addr;

    data_ram_core #(.ADDR_WIDTH(ADDR_WIDTH)) u_ram (
        .clk     (clk),
        .en_i    (ram_en),
        .we_i    (data_sram_we),
        .addr_i  (data_sram_addr[ADDR_WIDTH+1:2]),
        .wdata_i (data_sram_wdata),
        .rdata_o (ram_rdata)
    );

    assign led_merged = byte_merge(32'(led_q), data_sram_wdata, data_sram_we);

    always_comb begin
        mmio_rd = 32'h0;
        case (offset)
            OFF_LED:    mmio_rd = 32'(led_q);
            OFF_TIMER:  mmio_rd = timer_q;
            OFF_SWITCH: mmio_rd = 32'(sw_sync_q);
            default:    mmio_rd = 32'h0;
        endcase
    end

    // Timer write wins over that cycle's increment.
    always_comb begin
        led_d        = led_q;
        timer_d      = timer_q + 32'd1;
        tag_d        = tag_q;
        mmio_rdata_d = mmio_rdata_q;
        if (data_sram_en) begin
            if (is_mmio) begin
                tag_d        = TAG_MMIO;
                mmio_rdata_d = mmio_rd;
                if (is_store) begin
                    case (offset)
                        OFF_LED:   led_d   = led_merged[LED_WIDTH-1:0];
                        OFF_TIMER: timer_d = byte_merge(timer_q, data_sram_wdata, data_sram_we);
                        default:   ;
                    endcase
                end
            end else begin
                tag_d = TAG_RAM;
            end
        end
    end

    // Reset selects the zeroed MMIO capture, so rdata reads 0 without
    // touching the RAM output register.
    always_ff @(posedge clk) begin
        if (reset) begin
            led_q        <= '0;
            timer_q      <= '0;
            tag_q        <= TAG_MMIO;
            mmio_rdata_q <= '0;
            sw_meta_q    <= '0;
            sw_sync_q    <= '0;
        end else begin
            led_q        <= led_d;
            timer_q      <= timer_d;
            tag_q        <= tag_d;
            mmio_rdata_q <= mmio_rdata_d;
            sw_meta_q    <= switch_in;
            sw_sync_q    <= sw_meta_q;
        end
    end

    assign data_sram_rdata = (tag_q == TAG_RAM) ? ram_rdata : mmio_rdata_q;
    assign led_out         = led_q;

endmodule

// File: tb/tb_data_sram_resp.sv
// Randomized and directed bench for data_sram_resp against a flat
// array-and-variables model of the memory map.
module tb_data_sram_resp;

    localparam int          AW = 12;
    localparam logic [31:0] MB = 32'hBFAF_0000;

    logic        clk = 1'b0;
    logic        reset;
    logic        en;
    logic [3:0]  we;
    logic [31:0] addr, wdata, rdata;
    logic [15:0] switch_in, led_out;

    data_sram_resp #(.ADDR_WIDTH(AW), .MMIO_BASE(MB), .LED_WIDTH(16)) dut (
        .clk             (clk),
        .reset           (reset),
        .data_sram_en    (en),
        .data_sram_we    (we),
        .data_sram_addr  (addr),
        .data_sram_wdata (wdata),
        .data_sram_rdata (rdata),
        .switch_in       (switch_in),
        .led_out         (led_out)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Reference state: word array with per-byte "written" flags, plain regs.
    logic [31:0] m_mem [0:(1<<AW)-1];
    logic [3:0]  m_kn  [0:(1<<AW)-1];
    logic [31:0] m_led, m_timer, m_rd;
    logic [15:0] m_meta, m_sync;
    bit          m_rd_known = 0;

    task automatic model_update();
        int          idx;
        logic [31:0] rv, nt;
        logic [15:0] off;
        bit          rk;
        idx = int'(addr[AW+1:2]);
        off = addr[15:0];
        if (reset) begin
            m_rd = 0; m_rd_known = 1; m_led = 0; m_timer = 0; m_meta = 0; m_sync = 0;
            return;
        end
        nt = m_timer + 1;
        if (en) begin
            if (addr[31:16] == MB[31:16]) begin
                rk = 1;
                if (off == 16'h0)      rv = m_led;
                else if (off == 16'h4) rv = m_timer;
                else if (off == 16'h8) rv = {16'h0, m_sync};
                else                   rv = 0;
                for (int i = 0; i < 4; i++) begin
                    if (we[i] && off == 16'h0) m_led[8*i +: 8] = wdata[8*i +: 8];
                end
                m_led = m_led & 32'h0000_FFFF;
                if (off == 16'h4 && we != 0) begin
                    nt = m_timer;
                    for (int i = 0; i < 4; i++) if (we[i]) nt[8*i +: 8] = wdata[8*i +: 8];
                end
            end else begin
                rv = m_mem[idx];
                rk = (m_kn[idx] == 4'hF);
                for (int i = 0; i < 4; i++) begin
                    if (we[i]) begin
                        m_mem[idx][8*i +: 8] = wdata[8*i +: 8];
                        m_kn[idx][i] = 1'b1;
                    end
                end
            end
            m_rd = rv;
            m_rd_known = rk;
        end
        m_timer = nt;
        m_sync  = m_meta;
        m_meta  = switch_in;
    endtask

    task automatic step(input logic r, input logic e, input logic [3:0] w,
                        input logic [31:0] a, input logic [31:0] d);
        @(negedge clk);
        reset = r; en = e; we = w; addr = a; wdata = d;
        @(posedge clk);
        model_update();
        #1;
        if (m_rd_known) chk("rdata_model", rdata, m_rd);
        chk("led_model", 32'(led_out), m_led);
    endtask

    task automatic nop();
        step(0, 0, 4'h0, 32'h0, 32'h0);
    endtask

    initial begin
        logic [31:0] a;
        logic [15:0] offs [6];
        offs = '{16'h0, 16'h4, 16'h8, 16'h10, 16'hC, 16'h0};
        for (int i = 0; i < (1<<AW); i++) begin m_mem[i] = 0; m_kn[i] = 0; end
        m_led = 0; m_timer = 0; m_rd = 0; m_meta = 0; m_sync = 0;
        switch_in = 16'h0;
        reset = 1; en = 0; we = 0; addr = 0; wdata = 0;

        for (int i = 0; i < 3; i++) step(1, 1, 4'hF, 32'h100, 32'h1234_5678);
        chk("reset_rdata", rdata, 32'h0);
        chk("reset_led", 32'(led_out), 32'h0);

        // Timer counts from the first non-reset cycle.
        for (int i = 0; i < 10; i++) nop();
        step(0, 1, 4'h0, MB + 32'h4, 32'h0);
        chk("timer_cycle10", rdata, 32'd10);
        step(0, 1, 4'hF, MB + 32'h4, 32'hFFFF_FFFE);
        nop();
        step(0, 1, 4'h0, MB + 32'h4, 32'h0);
        chk("timer_ffffffff", rdata, 32'hFFFF_FFFF);
        nop();
        chk("rdata_hold", rdata, 32'hFFFF_FFFF);
        step(0, 1, 4'h0, MB + 32'h4, 32'h0);
        chk("timer_wrap", rdata, 32'h0000_0001);

        step(0, 1, 4'hF, 32'h100, 32'hDEAD_BEEF);
        step(0, 1, 4'h0, 32'h100, 32'h0);
        chk("ram_full_word", rdata, 32'hDEAD_BEEF);
        step(0, 1, 4'b0010, 32'h102, 32'h0000_5500);
        chk("read_first", rdata, 32'hDEAD_BEEF);
        step(0, 1, 4'h0, 32'h100, 32'h0);
        chk("ram_byte_merge", rdata, 32'hDEAD_55EF);

        step(0, 1, 4'hF, MB, 32'h0001_A5A5);
        chk("led_out_write", 32'(led_out), 32'h0000_A5A5);
        step(0, 1, 4'h0, MB, 32'h0);
        chk("led_read", rdata, 32'h0000_A5A5);
        step(1, 0, 4'h0, 32'h0, 32'h0);
        chk("led_reset", 32'(led_out), 32'h0);
        chk("rdata_reset", rdata, 32'h0);

        switch_in = 16'h3C3C;
        for (int i = 0; i < 3; i++) nop();
        step(0, 1, 4'h0, MB + 32'h8, 32'h0);
        chk("switch_read", rdata, 32'h0000_3C3C);
        step(0, 1, 4'hF, MB + 32'h8, 32'hFFFF_FFFF);
        step(0, 1, 4'hF, MB + 32'h10, 32'hFFFF_FFFF);
        step(0, 1, 4'h0, MB + 32'h8, 32'h0);
        chk("switch_ro", rdata, 32'h0000_3C3C);
        step(0, 1, 4'h0, MB + 32'h10, 32'h0);
        chk("unmapped_zero", rdata, 32'h0);
        chk("led_untouched", 32'(led_out), 32'h0);

        step(0, 1, 4'hF, 32'h0, 32'h1111_1111);
        step(0, 1, 4'hF, 32'(1) << (AW + 2), 32'h2222_2222);
        step(0, 1, 4'h0, 32'h0, 32'h0);
        chk("ram_alias", rdata, 32'h2222_2222);
        step(0, 1, 4'hF, MB, 32'h3333_3333);
        step(0, 1, 4'h0, 32'h0, 32'h0);
        chk("mmio_isolation", rdata, 32'h2222_2222);

        for (int n = 0; n < 600; n++) begin
            if ($urandom_range(0, 19) == 0) switch_in = 16'($urandom);
            if ($urandom_range(0, 2) == 0) begin
                a = MB + 32'(offs[$urandom_range(0, 5)]);
                if ($urandom_range(0, 5) == 0) a[15:0] = 16'($urandom);
            end else begin
                a = {16'($urandom), 16'h0};
                if (a[31:16] == MB[31:16]) a[31:16] = 16'h0;
                a[AW+1:2] = AW'($urandom_range(0, 15));
                a[1:0]    = 2'($urandom);
            end
            step($urandom_range(0, 59) == 0, $urandom_range(0, 3) != 0,
                 ($urandom_range(0, 1) == 0) ? 4'($urandom) : 4'h0, a, $urandom);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
